ifid_stage_control: RTL

Front-end pipeline controller owning the PC register and the IF/ID pipeline register. It consumes the `stall`/`flush` pair produced by hazard detection and the branch/jump redirect resolved in ID. It holds or advances fetch, squashes wrong-path instructions, and supplies the ID/EX bubble request. It also keeps saturating stall/flush event counters and a stuck-stall watchdog for debug.

---
 rtl/ifid_stage_control.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ifid_stage_control.sv
// ifid_stage_control
// Front-end pipeline controller: owns the fetch PC and the IF/ID pipeline
// register. It applies hazard stalls, squashes the wrong-path instruction on
// an ID-resolved redirect, drives the ID/EX bubble request and keeps
// saturating debug counters plus a sticky stuck-stall watchdog.
module ifid_stage_control #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          MAX_STALL = 4,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branchTakenID,
    input  logic [31:0]      branchTargetID,
    input  logic [31:0]      instrIF,
    output logic [31:0]      pcIF,
    output logic [31:0]      instrID,
    output logic [31:0]      pcPlus4ID,
    output logic             validID,
    output logic             idexBubble,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic             stallTimeout
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [7:0]       RUN_MAX     = 8'hFF;
    localparam logic [7:0]       STALL_LIMIT = 8'(MAX_STALL);

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc_plus4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [7:0]       r_run_len;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_instr_nxt;
    logic [31:0]      w_pc_plus4_nxt;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    logic [7:0]       w_run_len_nxt;
    logic             w_timeout_nxt;
    logic [31:0]      w_pc_plus4;

    // Sequential PC increment; 32-bit modulo so the top of memory wraps to 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-state and next-value logic: stall beats redirect beats normal fetch.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_pc_plus4_nxt  = r_pc_plus4;
        w_valid_nxt     = r_valid;
        w_stall_cnt_nxt = r_stall_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_run_len_nxt   = r_run_len;
        w_timeout_nxt   = r_timeout;

        case (r_state)
            ST_BOOT: begin
                // First fetch after reset; hazard inputs are not meaningful yet.
                w_pc_nxt       = w_pc_plus4;
                w_instr_nxt    = instrIF;
                w_pc_plus4_nxt = w_pc_plus4;
                w_valid_nxt    = 1'b1;
                w_run_len_nxt  = 8'd0;
                w_state_nxt    = ST_RUN;
            end
            ST_RUN, ST_STALLED: begin
                if (stall) begin
                    // Hold PC and IF/ID; a concurrent redirect is re-presented later.
                    if (r_stall_cnt != CNT_MAX) begin
                        w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
                    end else begin
                        w_stall_cnt_nxt = r_stall_cnt;
                    end
                    if (r_run_len != RUN_MAX) begin
                        w_run_len_nxt = r_run_len + 8'd1;
                    end else begin
                        w_run_len_nxt = r_run_len;
                    end
                    if (r_run_len >= STALL_LIMIT) begin
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_timeout_nxt = r_timeout;
                    end
                    w_state_nxt = ST_STALLED;
                end else if (branchTakenID) begin
                    // Redirect: squash the single wrong-path fetch in IF/ID.
                    w_pc_nxt       = branchTargetID;
                    w_instr_nxt    = NOP_INSTR;
                    w_pc_plus4_nxt = 32'd0;
                    w_valid_nxt    = 1'b0;
                    if (r_flush_cnt != CNT_MAX) begin
                        w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt;
                    end
                    w_run_len_nxt  = 8'd0;
                    w_state_nxt    = ST_RUN;
                end else begin
                    w_pc_nxt       = w_pc_plus4;
                    w_instr_nxt    = instrIF;
                    w_pc_plus4_nxt = w_pc_plus4;
                    w_valid_nxt    = 1'b1;
                    w_run_len_nxt  = 8'd0;
                    w_state_nxt    = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // State and pipeline registers; async reset returns everything to boot values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_pc_plus4  <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_run_len   <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_pc_plus4  <= w_pc_plus4_nxt;
            r_valid     <= w_valid_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_run_len   <= w_run_len_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign pcIF         = r_pc;
    assign instrID      = r_instr;
    assign pcPlus4ID    = r_pc_plus4;
    assign validID      = r_valid;
    assign stallCount   = r_stall_cnt;
    assign flushCount   = r_flush_cnt;
    assign stallTimeout = r_timeout;
    // Bubble is combinational so a same-cycle hazard flush takes effect at once.
    assign idexBubble   = flush | ~r_valid;

endmodule
